embcpu_nios2_qsys_0_oci_trace_monitor: RTL
==========================================

EMBCPU_NIOS2_QSYS_0_OCI_TRACE_MONITOR -- requirements
Module: embcpu_nios2_qsys_0_oci_trace_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 30: width of dct_buffer and of the captured word.
REQ-002 SHALL have parameter CNT_W, default 4: width of dct_count.
REQ-003 SHALL have parameter DEPTH, default 8, a power of 2 and at least 2: number of capture FIFO entries.
REQ-004 SHALL have parameter DROP_W, default 8: width of the drop counter.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port enable, input, 1 bit: arms capture from IDLE.
REQ-008 SHALL have port dct_buffer, input, DATA_W bits: debug trace word.
REQ-009 SHALL have port dct_count, input, CNT_W bits: trace word counter.
REQ-010 SHALL have port test_ending, input, 1 bit: request to stop capturing.
REQ-011 SHALL have port test_has_ended, input, 1 bit: simulation end flag.
REQ-012 SHALL have port rd_ready, input, 1 bit: consumer accepts rd_data.
REQ-013 SHALL have port rd_valid, output, 1 bit: FIFO head is valid.
REQ-014 SHALL have port rd_data, output, DATA_W bits: FIFO head word.
REQ-015 SHALL have port rd_seq, output, CNT_W bits: dct_count value captured with the head word.
REQ-016 SHALL have port fill_level, output, log2(DEPTH)+1 bits: entries held.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag, a push was dropped.
REQ-018 SHALL have port drop_count, output, DROP_W bits: dropped pushes, saturating.
REQ-019 SHALL have port state, output, 2 bits: IDLE=0, CAPTURE=1, DRAIN=2, DONE=3.
REQ-020 SHALL have port done, output, 1 bit: high iff state==DONE.

Function
REQ-021 SHALL register dct_count every cycle in every state as prev_count.
REQ-022 SHALL raise event when dct_count != prev_count.
REQ-023 SHALL push {dct_count, dct_buffer} on an event only while state==CAPTURE.
REQ-024 SHALL NOT generate a spurious event on entry to CAPTURE, because prev_count tracks in IDLE.
REQ-025 SHALL transition IDLE->CAPTURE when enable=1.
REQ-026 SHALL transition CAPTURE->DRAIN when test_ending=1 or test_has_ended=1.
REQ-027 SHALL capture an event occurring in the same cycle as the CAPTURE->DRAIN transition.
REQ-028 SHALL transition DRAIN->DONE when test_has_ended=1 and fill_level==0, or when test_has_ended=1, fill_level==1 and a pop occurs that cycle.
REQ-029 SHALL hold DONE until reset; in DONE, no pops, no pushes, rd_valid=0, and all outputs stay frozen.
REQ-030 SHALL assert rd_valid = (fill_level!=0) and state!=DONE; rd_data and rd_seq show the head word whenever rd_valid=1.
REQ-031 SHALL pop when rd_valid and rd_ready are both 1; a pop is allowed in CAPTURE and in DRAIN.
REQ-032 SHALL hold rd_data and rd_seq stable while rd_valid=1 and rd_ready=0.
REQ-033 SHALL be FIFO-ordered, with pointers of log2(DEPTH) bits wrapping modulo DEPTH.
REQ-034 SHALL, on push and pop in the same cycle when full, perform both; fill_level stays at DEPTH and nothing is dropped.
REQ-035 SHALL, on push and pop in the same cycle when empty, pop nothing (rd_valid=0), push the word, and end with fill_level=1.
REQ-036 SHALL, on push when full without a pop, discard the word, set overflow=1, and increment drop_count, saturating at 2^DROP_W-1.
REQ-037 SHALL give push-to-rd_valid latency of 1 cycle: a word pushed at edge N is visible after edge N.

Reset
REQ-038 SHALL, when reset_n=0 at a clk edge, set state=IDLE, empty the FIFO (fill_level=0, rd_valid=0), set overflow=0, drop_count=0, prev_count=0, done=0, and clear rd_data and rd_seq to 0.
REQ-039 SHALL apply reset mid-operation in any state with the same result, discarding FIFO contents.
REQ-040 SHALL ignore all inputs during a cycle in which reset_n=0.

Verification
REQ-041 SHALL cover basic capture: enable, then dct_count 0->1->2 with dct_buffer=0x1,0x2, rd_ready=1 -> rd_data 0x1 (rd_seq 1) then 0x2 (rd_seq 2), each one cycle after its push.
REQ-042 SHALL cover overflow: DEPTH=8, rd_ready=0, 10 events -> fill_level=8, overflow=1, drop_count=2; drain yields the first 8 words in order.
REQ-043 SHALL cover full push+pop: FIFO full, rd_ready=1 and an event in the same cycle -> fill_level remains 8 and drop_count is unchanged.
REQ-044 SHALL cover drain/done: 3 entries held, test_ending then test_has_ended, rd_ready=1 -> 3 pops, state goes 1->2->3, done=1 the cycle after the last pop; later events are ignored.
REQ-045 SHALL cover reset mid-DRAIN: fill_level=5, reset_n=0 for one edge -> state=0, fill_level=0, overflow=0, rd_valid=0.
REQ-046 SHALL cover IDLE tracking: dct_count changes 3 times before enable, then enable -> fill_level stays 0 until the next change.

Source files
------------

// File: rtl/embcpu_nios2_qsys_0_oci_trace_monitor.sv
// Trace capture monitor: watches the debug trace counter and pushes
// {dct_count, dct_buffer} into a small FIFO each time the counter changes
// while capturing. A consumer drains the FIFO with a valid/ready handshake.
// The run ends in DONE once the test has ended and the FIFO is empty.
//
// Ports:
//   clk, reset_n        - clock; synchronous active-low reset
//   enable              - arms capture from IDLE
//   dct_buffer/dct_count- trace word and its counter
//   test_ending         - stop capturing and start draining
//   test_has_ended      - stop capturing; allows DRAIN to finish in DONE
//   rd_valid/rd_ready   - FIFO head handshake; rd_data/rd_seq show the head
//   fill_level          - entries held
//   overflow/drop_count - sticky drop flag and saturating drop counter
//   state/done          - FSM state (IDLE=0 CAPTURE=1 DRAIN=2 DONE=3)
module embcpu_nios2_qsys_0_oci_trace_monitor #(
  parameter int unsigned DATA_W = 30,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [DATA_W-1:0]        dct_buffer,
  input  logic [CNT_W-1:0]         dct_count,
  input  logic                     test_ending,
  input  logic                     test_has_ended,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [CNT_W-1:0]         rd_seq,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count,
  output logic [1:0]               state,
  output logic                     done
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = CNT_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     prev_count_q, prev_count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     fill_q, fill_d;
  logic                 overflow_q, overflow_d;
  logic [DROP_W-1:0]    drop_count_q, drop_count_d;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [ENTRY_W-1:0]   mem_d [DEPTH];

  logic                 event_c;
  logic                 pop_c;
  logic                 push_req_c;
  logic                 push_c;
  logic                 drop_c;
  logic                 full_c;
  logic [ENTRY_W-1:0]   head_c;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (enable) state_d = ST_CAPTURE;
      ST_CAPTURE: if (test_ending || test_has_ended) state_d = ST_DRAIN;
      ST_DRAIN: begin
        // Finish once nothing is left after this cycle's pop.
        if (test_has_ended &&
            ((fill_q == '0) || ((fill_q == LVL_W'(1)) && pop_c)))
          state_d = ST_DONE;
      end
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    state      = state_q;
    done       = (state_q == ST_DONE);
    rd_valid   = (fill_q != '0) && (state_q != ST_DONE);
    head_c     = mem_q[rd_ptr_q];
    // Head is masked when empty so reset (and empty FIFO) shows zero.
    rd_data    = rd_valid ? head_c[DATA_W-1:0] : '0;
    rd_seq     = rd_valid ? head_c[ENTRY_W-1:DATA_W] : '0;
    fill_level = fill_q;
    overflow   = overflow_q;
    drop_count = drop_count_q;
  end

  // FIFO datapath: event detection, push/pop/drop, pointers and counters
  always_comb begin
    event_c      = (dct_count != prev_count_q);
    pop_c        = rd_valid && rd_ready &&
                   ((state_q == ST_CAPTURE) || (state_q == ST_DRAIN));
    push_req_c   = event_c && (state_q == ST_CAPTURE);
    full_c       = (fill_q == LVL_W'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_c       = push_req_c && (!full_c || pop_c);
    drop_c       = push_req_c && full_c && !pop_c;

    prev_count_d = dct_count;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q + LVL_W'(push_c) - LVL_W'(pop_c);
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    mem_d        = mem_q;

    if (push_c) begin
      mem_d[wr_ptr_q] = {dct_count, dct_buffer};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_count_q != {DROP_W{1'b1}})
        drop_count_d = drop_count_q + DROP_W'(1);
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      prev_count_q <= prev_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Storage array; contents are don't-care while not counted in fill_q
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
